// File: rtl/csd_pkg.sv
// Shared types and constants for the CSD shift-add coefficient multiplier.
package csd_pkg;

  // FSM state encoding (2-bit).
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAcc  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned CSD_WIDTH  = 41;
  localparam int unsigned CSD_NTERMS = 8;
  localparam int unsigned CSD_SHW    = 6;

  // Default loop coefficient: shifts {2,5,6,7,12}, all added, terms 5..7 disabled.
  localparam logic [CSD_NTERMS*CSD_SHW-1:0] CSD_C3_SHIFT =
      {6'd0, 6'd0, 6'd0, 6'd12, 6'd7, 6'd6, 6'd5, 6'd2};
  localparam logic [CSD_NTERMS-1:0] CSD_C3_NEG = 8'h00;
  localparam logic [CSD_NTERMS-1:0] CSD_C3_EN  = 8'h1f;

  // Place one shift amount into its term slot of a packed coef_shift word.
  function automatic logic [CSD_NTERMS*CSD_SHW-1:0] csd_shift_field(
      input int unsigned k, input logic [CSD_SHW-1:0] s);
    logic [CSD_NTERMS*CSD_SHW-1:0] f;
    f = '0;
    f[k*CSD_SHW +: CSD_SHW] = s;
    return f;
  endfunction

endpackage

// File: rtl/csd_coef_mult_seq_if.sv
// Operand/result handshake bundle for csd_coef_mult_seq.
interface csd_coef_mult_seq_if #(
  parameter int unsigned WIDTH  = 41,
  parameter int unsigned NTERMS = 8,
  parameter int unsigned SHW    = 6
);
  logic [NTERMS*SHW-1:0]   coef_shift;
  logic [NTERMS-1:0]       coef_neg;
  logic [NTERMS-1:0]       coef_en;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_data;

  // Source/sink side.
  modport master (
    output coef_shift, coef_neg, coef_en, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Multiplier side.
  modport slave (
    input  coef_shift, coef_neg, coef_en, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/csd_term.sv
// One CSD term: sign-saturating arithmetic right shift, optional negate, enable gate.
module csd_term #(
  parameter int unsigned WIDTH = 41,
  parameter int unsigned SHW   = 6
) (
  input  logic signed [WIDTH-1:0] data,
  input  logic [SHW-1:0]          shift,
  input  logic                    neg,
  input  logic                    en,
  output logic signed [WIDTH-1:0] term
);

  logic signed [WIDTH-1:0] shifted;

  // Floor-truncating shift; shifts past the word leave only sign bits.
  always_comb begin
    shifted = '0;
    term    = '0;
    if (32'(shift) >= WIDTH) begin
      shifted = {WIDTH{data[WIDTH-1]}};
    end else begin
      shifted = data >>> shift;
    end
    if (!en) begin
      term = '0;
    end else if (neg) begin
      term = -shifted;
    end else begin
      term = shifted;
    end
  end

endmodule

// File: rtl/csd_coef_mult_seq.sv
// Sequential programmable CSD multiplier: one shift-add term per clock.
module csd_coef_mult_seq
  import csd_pkg::*;
#(
  parameter int unsigned WIDTH  = 41,
  parameter int unsigned NTERMS = 8,
  parameter int unsigned SHW    = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  csd_coef_mult_seq_if.slave bus,
  output logic              busy
);

  localparam int unsigned IDXW = (NTERMS > 1) ? $clog2(NTERMS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NTERMS - 1);

  state_e                  state_q, state_d;
  logic signed [WIDTH-1:0] in_q, in_d;
  logic [NTERMS*SHW-1:0]   shift_q, shift_d;
  logic [NTERMS-1:0]       neg_q, neg_d;
  logic [NTERMS-1:0]       en_q, en_d;
  logic signed [WIDTH-1:0] acc_q, acc_d;
  logic [IDXW-1:0]         idx_q, idx_d;
  logic signed [WIDTH-1:0] out_data_q, out_data_d;
  logic                    out_valid_q, out_valid_d;
  logic                    in_ready;
  logic                    load;
  logic signed [WIDTH-1:0] term;
  logic signed [WIDTH-1:0] sum;

  csd_term #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_term (
    .data  (in_q),
    .shift (shift_q[idx_q*SHW +: SHW]),
    .neg   (neg_q[idx_q]),
    .en    (en_q[idx_q]),
    .term  (term)
  );

  // Next-state, accumulator update and handshake decode.
  always_comb begin
    state_d     = state_q;
    in_d        = in_q;
    shift_d     = shift_q;
    neg_d       = neg_q;
    en_d        = en_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    load        = 1'b0;
    sum         = acc_q + term;
    // out_ready feeds in_ready combinationally so DONE can hand over without a bubble.
    in_ready    = (state_q == StIdle) | ((state_q == StDone) & bus.out_ready);

    case (state_q)
      StIdle: begin
        if (bus.in_valid) load = 1'b1;
      end
      StAcc: begin
        acc_d = sum;
        idx_d = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          out_data_d  = sum;
          out_valid_d = 1'b1;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          if (bus.in_valid) begin
            load = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Coefficients are sampled only here; later changes cannot disturb a running product.
    if (load) begin
      in_d    = bus.in_data;
      shift_d = bus.coef_shift;
      neg_d   = bus.coef_neg;
      en_d    = bus.coef_en;
      acc_d   = '0;
      idx_d   = '0;
      state_d = StAcc;
    end
  end

  // State and datapath registers; reset abandons any product in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      in_q        <= '0;
      shift_q     <= '0;
      neg_q       <= '0;
      en_q        <= '0;
      acc_q       <= '0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_q        <= in_d;
      shift_q     <= shift_d;
      neg_q       <= neg_d;
      en_q        <= en_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign busy          = (state_q != StIdle);

endmodule
